// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT result readout path.
package fft_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_N         = 9;
  localparam int FFT_LEN       = 1 << DEF_N;

  typedef struct packed {
    logic signed [DEF_BIT_WIDTH-1:0] re;
    logic signed [DEF_BIT_WIDTH-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/readout_skid_fifo.sv
// Two-entry flow-through FIFO: when empty, the entry being pushed is visible at the head
// in the same cycle, so RAM data reaches the output the cycle it returns.
module readout_skid_fifo #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         head_valid,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0) || push;
  assign head_data  = (count_q == 2'd0) ? push_data : mem0_q;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (count_q == 2'd0) begin
      if (push && !pop) begin
        mem0_d  = push_data;
        count_d = 2'd1;
      end
    end else if (count_q == 2'd1) begin
      if (push && pop) begin
        mem0_d = push_data;
      end else if (push) begin
        mem1_d  = push_data;
        count_d = 2'd2;
      end else if (pop) begin
        count_d = 2'd0;
      end
    end else begin
      // Full: the issuer never pushes here without a matching pop.
      if (pop) begin
        mem0_d = mem1_q;
        if (push) mem1_d = push_data;
        else      count_d = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fft_readout.sv
// Streams a finished FFT frame out of the selected ping-pong RAM in natural bin order
// over a valid/ready interface, one bin per cycle when the sink keeps up.
module fft_readout import fft_pkg::*; #(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = DEF_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  input  logic                   read_sel,
  output logic [N-1:0]           rd_add,
  output logic                   rd_en,
  input  logic [2*BIT_WIDTH-1:0] r0_rdata,
  input  logic [2*BIT_WIDTH-1:0] r1_rdata,
  output logic [2*BIT_WIDTH-1:0] out_data,
  output logic [N-1:0]           out_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   unload_done,
  output logic                   overrun
);

  localparam int         W    = 2 * BIT_WIDTH;
  localparam logic [N:0] LAST = {1'b0, {N{1'b1}}};

  rd_state_e      state_q, state_d;
  logic           bank_q, bank_d;
  logic [N:0]     iss_q, iss_d, oidx_q, oidx_d;
  logic           rd_en_q, rd_en_d;
  logic [N-1:0]   rd_add_q, rd_add_d;
  logic           inflight_q, inflight_d;
  logic [N-1:0]   inflight_idx_q, inflight_idx_d;
  logic           busy_q, busy_d, unload_done_q, unload_done_d, overrun_q, overrun_d;

  logic [1:0]     fifo_count;
  logic           head_valid, accept;
  logic [W+N-1:0] head_data;
  logic [2:0]     occ_next;

  readout_skid_fifo #(.W(W + N)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q),
    .push_data  ({bank_q ? r1_rdata : r0_rdata, inflight_idx_q}),
    .pop        (accept),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign accept      = head_valid && out_ready;
  assign out_valid   = head_valid;
  assign out_data    = head_valid ? head_data[W+N-1:N] : '0;
  assign out_idx     = head_valid ? head_data[N-1:0] : '0;
  assign out_last    = head_valid && (head_data[N-1:0] == LAST[N-1:0]);
  assign rd_en       = rd_en_q;
  assign rd_add      = rd_add_q;
  assign busy        = busy_q;
  assign unload_done = unload_done_q;
  assign overrun     = overrun_q;

  // Slots held next cycle: buffered + returning + the read issued this cycle.
  assign occ_next = {1'b0, fifo_count} + {2'b0, inflight_q} + {2'b0, rd_en_q} - {2'b0, accept};

  always_comb begin
    state_d        = state_q;
    bank_d         = bank_q;
    iss_d          = iss_q;
    oidx_d         = accept ? oidx_q + 1'b1 : oidx_q;
    rd_en_d        = 1'b0;
    rd_add_d       = rd_add_q;
    inflight_d     = rd_en_q;
    inflight_idx_d = rd_add_q;
    busy_d         = busy_q;
    unload_done_d  = 1'b0;
    overrun_d      = overrun_q || (fft_done && (busy_q || unload_done_q));
    case (state_q)
      IDLE: begin
        if (fft_done && !unload_done_q) begin
          state_d  = READ;
          bank_d   = read_sel;
          busy_d   = 1'b1;
          oidx_d   = '0;
          rd_en_d  = 1'b1;
          rd_add_d = '0;
          iss_d    = {{N{1'b0}}, 1'b1};
        end
      end
      READ: begin
        if (occ_next < 3'd2) begin
          rd_en_d  = 1'b1;
          rd_add_d = iss_q[N-1:0];
          iss_d    = iss_q + 1'b1;
          if (iss_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && oidx_q == LAST) begin
          state_d       = IDLE;
          busy_d        = 1'b0;
          unload_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      bank_q         <= 1'b0;
      iss_q          <= '0;
      oidx_q         <= '0;
      rd_en_q        <= 1'b0;
      rd_add_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      busy_q         <= 1'b0;
      unload_done_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bank_q         <= bank_d;
      iss_q          <= iss_d;
      oidx_q         <= oidx_d;
      rd_en_q        <= rd_en_d;
      rd_add_q       <= rd_add_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      busy_q         <= busy_d;
      unload_done_q  <= unload_done_d;
      overrun_q      <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fft_readout.sv
// Bench for fft_readout with 16 bins: frame table, random frames, reset and overrun sequences.
module tb_fft_readout;
  import fft_pkg::*;

  localparam int BW  = 16;
  localparam int NB  = 4;
  localparam int LEN = 1 << NB;

  logic            clk = 1'b0, reset = 1'b0, fft_done = 1'b0, read_sel = 1'b0, out_ready = 1'b0;
  logic [NB-1:0]   rd_add, out_idx;
  logic            rd_en, out_valid, out_last, busy, unload_done, overrun;
  logic [2*BW-1:0] r0_rdata = '0, r1_rdata = '0, out_data;
  logic [2*BW-1:0] ram0 [LEN];
  logic [2*BW-1:0] ram1 [LEN];

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit sel;
    bit flip;
    int mode;
    int ovr_at;
    int abort_at;
    int exp_done;
    bit exp_ovr;
  } vec_t;

  vec_t tbl [7];

  fft_readout #(.BIT_WIDTH(BW), .N(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .fft_done    (fft_done),
    .read_sel    (read_sel),
    .rd_add      (rd_add),
    .rd_en       (rd_en),
    .r0_rdata    (r0_rdata),
    .r1_rdata    (r1_rdata),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .unload_done (unload_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Port-A RAM models: one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) begin
      r0_rdata <= ram0[rd_add];
      r1_rdata <= ram1[rd_add];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2*BW-1:0] exp_bin(input bit bank, input int i);
    complex_t c;
    if (!bank) begin
      c.re = 16'(i);
      c.im = -16'(i);
    end else begin
      c.re = 16'(100 + i);
      c.im = '0;
    end
    return c;
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      2:       return 1'($urandom_range(0, 1));
      default: return c > 20;
    endcase
  endfunction

  task automatic run_frame(input int id, input vec_t v);
    int acc = 0, issued = 0, done_c = -1, seen = 0;
    bit timing, ovr_done = 0;
    timing = (v.mode == 0) && (v.exp_done >= 0);
    @(posedge clk); #1;
    for (int c = 0; c < 300; c++) begin
      fft_done = (c == 0);
      if (!ovr_done && v.ovr_at >= 0 && c > 0 && acc == v.ovr_at) begin
        fft_done = 1'b1;
        ovr_done = 1'b1;
      end
      if (c == 0) read_sel = v.sel;
      else if (c == 1 && v.flip) read_sel = ~v.sel;
      out_ready = ready_for(v.mode, c);
      if (v.abort_at >= 0 && acc == v.abort_at) begin
        out_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rden", rd_en, 0);
        chk("rst_overrun", overrun, 0);
        $display("frame %0d: reset applied at bin %0d", id, acc);
        return;
      end
      @(negedge clk);
      if (rd_en) begin
        issued++;
        chk("outstanding", (issued - acc) <= 2, 1);
      end
      if (timing) begin
        chk("busy_t", busy, (c >= 1 && c <= 17));
        chk("rden_t", rd_en, (c >= 1 && c <= 16));
        chk("valid_t", out_valid, (c >= 2 && c <= 17));
      end
      if (out_valid) begin
        chk("idx", out_idx, acc[NB-1:0]);
        chk("data", out_data, exp_bin(v.sel, acc));
        chk("last", out_last, acc == LEN - 1);
        if (out_ready) acc++;
      end
      if (v.mode == 3 && c == 20) chk("stall_reads", issued, 2);
      if (unload_done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    fft_done = 1'b0;
    chk("bins", acc, LEN);
    if (v.exp_done >= 0) chk("done_cycle", done_c, v.exp_done);
    else chk("done_seen", done_c >= 0, 1);
    chk("overrun", overrun, v.exp_ovr);
    if (v.exp_ovr) begin
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (rd_en || out_valid || busy) seen++;
      end
      chk("no_restart", seen, 0);
      chk("overrun_sticky", overrun, 1);
    end
    $display("frame %0d: sel=%0d mode=%0d bins=%0d done_cycle=%0d overrun=%0b",
             id, v.sel, v.mode, acc, done_c, overrun);
  endtask

  initial begin
    vec_t rv;
    int idle_bad;
    for (int i = 0; i < LEN; i++) begin
      ram0[i] = {16'(i), 16'(-i)};
      ram1[i] = {16'(100 + i), 16'd0};
    end
    tbl[0] = '{sel: 0, flip: 0, mode: 0, ovr_at: -1, abort_at: -1, exp_done: 18, exp_ovr: 0};
    tbl[1] = '{sel: 1, flip: 1, mode: 0, ovr_at: -1, abort_at: -1, exp_done: 18, exp_ovr: 0};
    tbl[2] = '{sel: 0, flip: 0, mode: 1, ovr_at: -1, abort_at: -1, exp_done: -1, exp_ovr: 0};
    tbl[3] = '{sel: 1, flip: 0, mode: 3, ovr_at: -1, abort_at: -1, exp_done: -1, exp_ovr: 0};
    tbl[4] = '{sel: 0, flip: 0, mode: 0, ovr_at: 5,  abort_at: -1, exp_done: 18, exp_ovr: 1};
    tbl[5] = '{sel: 1, flip: 0, mode: 1, ovr_at: -1, abort_at: 7,  exp_done: -1, exp_ovr: 0};
    tbl[6] = '{sel: 0, flip: 0, mode: 0, ovr_at: -1, abort_at: -1, exp_done: 18, exp_ovr: 0};

    @(negedge clk);
    chk("reset_rd_add", rd_add, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_idx", out_idx, 0);
    chk("reset_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", unload_done, 0);
    chk("reset_overrun", overrun, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 7; k++) begin
      run_frame(k, tbl[k]);
      if (tbl[k].abort_at >= 0) begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle_bad = 0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (out_valid || rd_en || busy) idle_bad++;
        end
        chk("post_reset_idle", idle_bad, 0);
      end
    end

    for (int k = 0; k < 6; k++) begin
      rv = '{sel: 1'($urandom_range(0, 1)), flip: 1'($urandom_range(0, 1)), mode: 2,
             ovr_at: -1, abort_at: -1, exp_done: -1, exp_ovr: 0};
      run_frame(7 + k, rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
